ro_frequency_counter: RTL
=========================

# ro_frequency_counter

Measurement front-end for the free-running ring oscillator. It raises the oscillator enable, lets the ring settle, and counts oscillator rising edges over a fixed gate window of system-clock cycles. It then drops the enable and reports the count with a one-cycle valid strobe. It sits between the ring oscillator instance (drives its `iEn`, consumes its `oOsc`) and the host logic that triggers and reads measurements.

## Interface
Parameters:
- `GATE_CYCLES`, default 1024: length of the counting window in `iClk` cycles. Must be ≥ 1.
- `SETTLE_CYCLES`, default 8: cycles between enabling the ring and opening the gate. Must be ≥ 3, which covers synchronizer flush.
- `COUNT_WIDTH`, default 16: width of the edge count.

Ports:
- `iClk` in, 1: system clock. All state is on its rising edge.
- `iRstN` in, 1: asynchronous, active-low reset.
- `iStart` in, 1: measurement request. Sampled only in IDLE.
- `iOsc` in, 1: ring oscillator output. Asynchronous to `iClk`.
- `oEn` out, 1: ring oscillator enable.
- `oBusy` out, 1: high whenever the state is not IDLE.
- `oValid` out, 1: one-cycle strobe; `oCount` is new.
- `oCount` out, `COUNT_WIDTH`: last completed measurement.

## Operation
- `iOsc` passes through a 2-flop synchronizer, then a history flop. A rising edge is detected when the synchronized bit is 1 and the history flop is 0. The edge flag is registered.
- FSM states: IDLE, SETTLE, GATE, DONE.
  - IDLE: `oEn`=0. When `iStart`=1, go to SETTLE, load the cycle counter, and clear the edge counter.
  - SETTLE: `oEn`=1. Stay for exactly `SETTLE_CYCLES` cycles, then go to GATE and reload the cycle counter. Edges in SETTLE are not counted.
  - GATE: `oEn`=1. Stay for exactly `GATE_CYCLES` cycles. Each cycle with the registered edge flag set increments the edge counter. The counter saturates at 2^`COUNT_WIDTH`−1 and does not wrap.
  - DONE: `oEn`=0. Latch the edge counter into `oCount` and assert `oValid` for this single cycle. Next state is IDLE unconditionally.
- `iStart` is ignored in SETTLE, GATE and DONE; there is no queueing. A start held high continuously yields back-to-back measurements, one every `SETTLE_CYCLES`+`GATE_CYCLES`+2 cycles.
- `oCount` holds its value until the next DONE.
- Measurement is valid only when the oscillator frequency is below f(`iClk`)/2. Above that, edges alias, and this is a documented limitation rather than an error.

## Timing
- Reset values: state IDLE, `oEn`=0, `oBusy`=0, `oValid`=0, `oCount`=0, synchronizer/history/edge flops 0, both counters 0.
- `iStart` is high at edge N in IDLE:
  - `oEn`/`oBusy` rise after edge N.
  - GATE occupies cycles N+1+`SETTLE_CYCLES` through N+`SETTLE_CYCLES`+`GATE_CYCLES`.
  - `oValid`=1 and `oEn`=0 in the following cycle (DONE).
  - `oBusy` falls one cycle later.
- Edge-detect latency from `iOsc` to edge flag is 3–4 `iClk` cycles. The gate is therefore counted as a window shifted by that latency; `SETTLE_CYCLES` ≥ 3 keeps pre-enable history out of the window.
- Reset asserted mid-measurement: all outputs return to reset values immediately (asynchronously), `oEn` drops, no `oValid` is produced, and the previous `oCount` is lost (reads 0).
- Counter widths: the cycle counter is sized as clog2 of max(`GATE_CYCLES`, `SETTLE_CYCLES`)+1 bits.

## Structure
- Shared package/header: FSM state encoding (IDLE=0, SETTLE=1, GATE=2, DONE=3) and a clog2 helper function.
- One sub-module, `osc_edge_detect`: 2-flop synchronizer, history flop and registered rising-edge flag, with async active-low reset. Its synchronizer flops carry the dont_touch/ASYNC_REG attributes.
- The top level holds the FSM, the cycle counter, the saturating edge counter and the output registers.
- In synthesis the ring oscillator instance stays outside this block.

## Test plan
- **Nominal:** `GATE_CYCLES`=100, `SETTLE_CYCLES`=4; bench `iOsc` toggles every 2 `iClk` cycles while `oEn`=1 (period 4) → `oValid` pulses once 106 cycles after start, `oCount`=25 (±1).
- **Stuck oscillator:** `iOsc` held 0 → `oCount`=0, `oValid` timing unchanged.
- **Saturation:** `COUNT_WIDTH`=4, `GATE_CYCLES`=100, `iOsc` period 4 → `oCount`=15. No wrap: the result is 15, not 25 mod 16 = 9.
- **Start while busy:** pulse `iStart` during SETTLE, GATE and DONE → exactly one `oValid`, `oBusy` low afterward, no second `oEn` high period.
- **Reset mid-gate:** drop `iRstN` halfway through GATE → `oEn`, `oBusy`, `oValid`, `oCount` all 0 immediately. After release and a new start, the full measurement gives the nominal result.
- **Back-to-back:** `iStart` held high, `iOsc` period 8 → `oValid` every 106 cycles, each `oCount`=12 (±1), `oEn` low for exactly 2 cycles between windows.

Source files
------------

// File: rtl/ro_frequency_counter_pkg.sv
// Shared definitions for the ring-oscillator frequency counter: FSM encoding
// and a constant-width helper.
package ro_frequency_counter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_GATE   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ro_frequency_counter_osc_edge_detect.sv
// Brings the free-running oscillator into the iClk domain and flags each
// rising edge with a registered one-cycle pulse.
module osc_edge_detect
    import ro_frequency_counter_pkg::*;
(
    input  logic iClk,
    input  logic iRstN,
    input  logic iOsc,
    output logic oEdge
);

    (* dont_touch = "true", ASYNC_REG = "TRUE" *) logic sync1_q;
    (* dont_touch = "true", ASYNC_REG = "TRUE" *) logic sync2_q;
    logic hist_q;
    logic edge_q;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= iOsc;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            edge_q  <= sync2_q & ~hist_q;
        end
    end

    assign oEdge = edge_q;

endmodule

// File: rtl/ro_frequency_counter.sv
// Ring-oscillator frequency counter: enables the ring, waits for it to settle,
// counts synchronized rising edges over a fixed gate and reports the result.
module ro_frequency_counter
    import ro_frequency_counter_pkg::*;
#(
    parameter int GATE_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 8,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   iClk,
    input  logic                   iRstN,
    input  logic                   iStart,
    input  logic                   iOsc,
    output logic                   oEn,
    output logic                   oBusy,
    output logic                   oValid,
    output logic [COUNT_WIDTH-1:0] oCount
);

    localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int CYC_W   = clog2(MAX_CYC + 1);

    localparam logic [CYC_W-1:0]       SETTLE_LOAD = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0]       GATE_LOAD   = CYC_W'(GATE_CYCLES - 1);
    localparam logic [CYC_W-1:0]       CYC_ONE     = CYC_W'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);

    logic [1:0]             state_q, state_d;
    logic [CYC_W-1:0]       cyc_q, cyc_d;
    logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   valid_q, valid_d;
    logic                   osc_edge;

    osc_edge_detect u_edge (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iOsc  (iOsc),
        .oEdge (osc_edge)
    );

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        edge_cnt_d = edge_cnt_q;
        count_d    = count_q;
        valid_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d    = ST_SETTLE;
                    cyc_d      = SETTLE_LOAD;
                    edge_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (cyc_q == '0) begin
                    state_d = ST_GATE;
                    cyc_d   = GATE_LOAD;
                end else begin
                    cyc_d = cyc_q - CYC_ONE;
                end
            end
            ST_GATE: begin
                // Saturate rather than wrap so an overrange ring reads as full-scale.
                if (osc_edge && (edge_cnt_q != CNT_MAX)) begin
                    edge_cnt_d = edge_cnt_q + CNT_ONE;
                end
                if (cyc_q == '0) begin
                    state_d = ST_DONE;
                    count_d = edge_cnt_d;
                    valid_d = 1'b1;
                end else begin
                    cyc_d = cyc_q - CYC_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            edge_cnt_q <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            edge_cnt_q <= edge_cnt_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
        end
    end

    assign oEn    = (state_q == ST_SETTLE) || (state_q == ST_GATE);
    assign oBusy  = (state_q != ST_IDLE);
    assign oValid = valid_q;
    assign oCount = count_q;

endmodule
